fifo_ctrl: RTL and testbench

Pointer and flag controller for the dual-port memory (`DATA_BITS`/`ADDR_BITS` parameterised RAM) in the data path. It sits directly upstream of that memory. It turns a push/pop request interface into the memory's `write`, `read`, `addr_write` and `addr_read` controls, and tracks occupancy to produce full, empty and threshold flags. Together with the memory it forms a 2^`ADDR_BITS`-deep synchronous FIFO.

---
 rtl/fifo_ctrl.sv | 94 +++++++++
 tb/tb_fifo_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag controller that turns push/pop requests into
// dual-port RAM controls for a 2^ADDR_BITS-deep FIFO. Define FIFO_CTRL_ERROR_EN for a sticky error flag.
module fifo_ctrl #(
    parameter int DATA_BITS = 8,
    parameter int ADDR_BITS = 6
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 push,
    input  logic                 pop,
    input  logic [ADDR_BITS:0]   almost_full_thr,
    input  logic [ADDR_BITS:0]   almost_empty_thr,
    output logic                 write,
    output logic                 read,
    output logic [ADDR_BITS-1:0] addr_write,
    output logic [ADDR_BITS-1:0] addr_read,
    output logic [ADDR_BITS:0]   count,
    output logic                 full,
    output logic                 empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 valid_out,
    output logic                 error
);
    localparam logic [ADDR_BITS:0]   DEPTH   = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS-1:0] PTR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0]   CNT_ONE = {{ADDR_BITS{1'b0}}, 1'b1};

    logic [ADDR_BITS-1:0] r_wr_ptr;
    logic [ADDR_BITS-1:0] r_rd_ptr;
    logic [ADDR_BITS:0]   r_count;
    logic                 r_valid_out;
    logic                 w_write;
    logic                 w_read;
    logic                 w_unused_data_bits;

    // DATA_BITS only describes the attached memory; it is carried for pass-through.
    assign w_unused_data_bits = ^DATA_BITS;

    assign full         = (r_count == DEPTH);
    assign empty        = (r_count == '0);
    assign almost_full  = (r_count >= almost_full_thr);
    assign almost_empty = (r_count <= almost_empty_thr);

    assign w_write = push & ~full;
    assign w_read  = pop & ~empty;

    assign write      = w_write;
    assign read       = w_read;
    assign addr_write = r_wr_ptr;
    assign addr_read  = r_rd_ptr;
    assign count      = r_count;
    assign valid_out  = r_valid_out;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_valid_out <= 1'b0;
        end else begin
            // Pointers are exactly ADDR_BITS wide, so they wrap modulo DEPTH for free.
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_read) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_write, w_read})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            r_valid_out <= w_read;
        end
    end

`ifdef FIFO_CTRL_ERROR_EN
    logic r_error;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_error <= 1'b0;
        end else if ((push & full) | (pop & empty)) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl: a behavioural RAM beside the DUT, a queue-based
// reference model, a small vector table, directed corner sequences and a random phase.
module tb_fifo_ctrl;
    localparam int AB    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [AB:0]   af_thr = 7'd60;
    logic [AB:0]   ae_thr = 7'd4;
    logic          write, read;
    logic [AB-1:0] addr_write, addr_read;
    logic [AB:0]   count;
    logic          full, empty, almost_full, almost_empty, valid_out, error;
    logic [7:0]    din = 8'h00;
    logic [7:0]    dout;
    logic [7:0]    mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: stored words in a queue, accepted-transfer totals, expected flags.
    logic [7:0] q[$];
    int         wr_total;
    int         rd_total;
    bit         m_valid;
    bit         m_err;
    logic [7:0] m_dout;

    typedef struct {
        bit p;
        bit po;
        bit ew;
        bit er;
        int cnt;
        bit e;
        bit ae;
        bit af;
    } vec_t;
    vec_t tbl [8];

    fifo_ctrl #(.DATA_BITS(8), .ADDR_BITS(AB)) dut (
        .clk              (clk),
        .reset_L          (reset_L),
        .push             (push),
        .pop              (pop),
        .almost_full_thr  (af_thr),
        .almost_empty_thr (ae_thr),
        .write            (write),
        .read             (read),
        .addr_write       (addr_write),
        .addr_read        (addr_read),
        .count            (count),
        .full             (full),
        .empty            (empty),
        .almost_full      (almost_full),
        .almost_empty     (almost_empty),
        .valid_out        (valid_out),
        .error            (error)
    );

    always #5 clk = ~clk;

    // Behavioural dual-port RAM with registered read, driven by the DUT controls.
    always @(posedge clk) begin
        if (write) mem[addr_write] <= din;
        if (read)  dout <= mem[addr_read];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wr_total = 0;
        rd_total = 0;
        m_valid  = 1'b0;
        m_err    = 1'b0;
    endtask

    // Called at a falling edge: drive, check write/read, clock, update model, return at next falling edge.
    task automatic step(input bit p, input bit po, input logic [7:0] d, output bit w_act, output bit r_act);
        bit ew, er;
        push = p;
        pop  = po;
        din  = d;
        #1;
        ew = p && (q.size() < DEPTH);
        er = po && (q.size() > 0);
        w_act = write;
        r_act = read;
        chk("write", {31'd0, write}, {31'd0, ew});
        chk("read", {31'd0, read}, {31'd0, er});
        if ((p && q.size() == DEPTH) || (po && q.size() == 0)) m_err = 1'b1;
        @(posedge clk);
        if (er) begin
            m_dout = q.pop_front();
            rd_total++;
        end
        if (ew) begin
            q.push_back(d);
            wr_total++;
        end
        m_valid = er;
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
        $display("step push=%0b pop=%0b din=%0d -> count=%0d valid=%0b dout=%0d", p, po, d, count, valid_out, dout);
    endtask

    task automatic check_state(input string tag);
        bit exp_error;
`ifdef FIFO_CTRL_ERROR_EN
        exp_error = m_err;
`else
        exp_error = 1'b0;
`endif
        chk({tag, "_count"}, {25'd0, count}, q.size());
        chk({tag, "_full"}, {31'd0, full}, {31'd0, q.size() == DEPTH});
        chk({tag, "_empty"}, {31'd0, empty}, {31'd0, q.size() == 0});
        chk({tag, "_afull"}, {31'd0, almost_full}, {31'd0, q.size() >= int'(af_thr)});
        chk({tag, "_aempty"}, {31'd0, almost_empty}, {31'd0, q.size() <= int'(ae_thr)});
        chk({tag, "_addr_wr"}, {26'd0, addr_write}, wr_total % DEPTH);
        chk({tag, "_addr_rd"}, {26'd0, addr_read}, rd_total % DEPTH);
        chk({tag, "_valid"}, {31'd0, valid_out}, {31'd0, m_valid});
        if (m_valid) chk({tag, "_dout"}, {24'd0, dout}, {24'd0, m_dout});
        chk({tag, "_error"}, {31'd0, error}, {31'd0, exp_error});
    endtask

    // Asynchronous reset pulse between edges; outputs must change before any clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 reset_L = 1'b0;
        #1;
        chk("rst_count", {25'd0, count}, 0);
        chk("rst_empty", {31'd0, empty}, 1);
        chk("rst_full", {31'd0, full}, 0);
        chk("rst_aempty", {31'd0, almost_empty}, 1);
        chk("rst_afull", {31'd0, almost_full}, {31'd0, af_thr == 0});
        chk("rst_valid", {31'd0, valid_out}, 0);
        chk("rst_addr_wr", {26'd0, addr_write}, 0);
        chk("rst_addr_rd", {26'd0, addr_read}, 0);
        chk("rst_error", {31'd0, error}, 0);
        @(negedge clk);
        reset_L = 1'b1;
        model_reset();
    endtask

    initial begin
        bit wa, ra;
        logic [7:0] r;

        tbl[0] = '{1, 0, 1, 0, 1, 0, 1, 0};
        tbl[1] = '{1, 0, 1, 0, 2, 0, 0, 1};
        tbl[2] = '{1, 1, 1, 1, 2, 0, 0, 1};
        tbl[3] = '{0, 1, 0, 1, 1, 0, 1, 0};
        tbl[4] = '{0, 1, 0, 1, 0, 1, 1, 0};
        tbl[5] = '{0, 1, 0, 0, 0, 1, 1, 0};
        tbl[6] = '{1, 1, 1, 0, 1, 0, 1, 0};
        tbl[7] = '{0, 0, 0, 0, 1, 0, 1, 0};

        model_reset();
        repeat (2) @(negedge clk);
        chk("por_count", {25'd0, count}, 0);
        chk("por_afull", {31'd0, almost_full}, 0);
        reset_L = 1'b1;

        // Reset then idle
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'd0, wa, ra);
        check_state("idle");

        // Vector table, thresholds af=2 ae=1
        af_thr = 7'd2;
        ae_thr = 7'd1;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].p, tbl[i].po, 8'(i + 1), wa, ra);
            chk("tbl_write", {31'd0, wa}, {31'd0, tbl[i].ew});
            chk("tbl_read", {31'd0, ra}, {31'd0, tbl[i].er});
            chk("tbl_count", {25'd0, count}, tbl[i].cnt);
            chk("tbl_empty", {31'd0, empty}, {31'd0, tbl[i].e});
            chk("tbl_aempty", {31'd0, almost_empty}, {31'd0, tbl[i].ae});
            chk("tbl_afull", {31'd0, almost_full}, {31'd0, tbl[i].af});
        end
        do_reset();

        // Fill 0..63 with af threshold 60, then overflow push
        af_thr = 7'd60;
        ae_thr = 7'd4;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i), wa, ra);
            check_state("fill");
            if (i == 58) chk("fill_af_before", {31'd0, almost_full}, 0);
            if (i == 59) chk("fill_af_after", {31'd0, almost_full}, 1);
        end
        chk("fill_full", {31'd0, full}, 1);
        chk("fill_addr_wrap", {26'd0, addr_write}, 0);
        step(1'b1, 1'b0, 8'hAA, wa, ra);
        chk("ovf_count", {25'd0, count}, 64);
        check_state("ovf");
        af_thr = 7'd65;
        #1 chk("af_thr_above_depth", {31'd0, almost_full}, 0);
        af_thr = 7'd64;
        #1 chk("af_thr_at_depth", {31'd0, almost_full}, 1);

        // Drain 0..63, then underflow pop
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, 1'b1, 8'd0, wa, ra);
            chk("drain_valid", {31'd0, valid_out}, 1);
            chk("drain_data", {24'd0, dout}, i);
            check_state("drain");
        end
        step(1'b0, 1'b1, 8'd0, wa, ra);
        check_state("udf");
        ae_thr = 7'd0;
        #1 chk("ae_thr0_empty", {31'd0, almost_empty}, 1);

        // Simultaneous push/pop at empty: only the write happens
        step(1'b1, 1'b1, 8'h3C, wa, ra);
        chk("sim_empty_count", {25'd0, count}, 1);
        chk("sim_empty_valid", {31'd0, valid_out}, 0);
        chk("ae_thr0_nonempty", {31'd0, almost_empty}, 0);
        check_state("sim_empty");
        do_reset();

        // Simultaneous push/pop at full: only the read happens
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i + 100), wa, ra);
        step(1'b1, 1'b1, 8'hEE, wa, ra);
        chk("sim_full_count", {25'd0, count}, 63);
        chk("sim_full_dout", {24'd0, dout}, 100);
        check_state("sim_full");
        step(1'b1, 1'b0, 8'h11, wa, ra);
        check_state("refull");
        do_reset();

        // Streaming wrap: pop every cycle from the second push on
        ae_thr = 7'd4;
        step(1'b1, 1'b0, 8'($urandom), wa, ra);
        for (int i = 1; i < 100; i++) begin
            step(1'b1, 1'b1, 8'($urandom), wa, ra);
            chk("stream_count", {25'd0, count}, 1);
            check_state("stream");
        end
        step(1'b0, 1'b1, 8'd0, wa, ra);
        check_state("stream_end");

        // Mid-operation reset at count 37, next push lands at address 0
        for (int i = 0; i < 37; i++) step(1'b1, 1'b0, 8'($urandom), wa, ra);
        chk("pre_rst_count", {25'd0, count}, 37);
        do_reset();
        chk("post_rst_addr", {26'd0, addr_write}, 0);
        step(1'b1, 1'b0, 8'h5C, wa, ra);
        step(1'b0, 1'b1, 8'd0, wa, ra);
        chk("post_rst_data", {24'd0, dout}, 8'h5C);
        check_state("post_rst");

        // Random traffic with varying thresholds and push/pop bias
        for (int ph = 0; ph < 6; ph++) begin
            int pp, pq;
            af_thr = 7'($urandom_range(0, 70));
            ae_thr = 7'($urandom_range(0, 64));
            pp = (ph % 2 == 0) ? 80 : 30;
            pq = (ph % 2 == 0) ? 30 : 80;
            for (int i = 0; i < 120; i++) begin
                r = 8'($urandom);
                step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq, r, wa, ra);
                check_state("rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
